in_line_reorder: RTL and testbench
==================================

Name: in_line_reorder

Overview:
- Line-buffering AXI-Stream style reorder stage for the DWT path.
- Accepts one image line of interleaved samples, where the even index is the low-pass sample and the odd index is the high-pass sample.
- Re-emits the same line with all even-indexed samples first, then all odd-indexed samples.
- Sits between the 1-D lifting DWT output and the next filtering stage. Optional ping-pong buffering lets the next line be written while the current one is read.

Parameters:
- DataWidth, 8: bits per sample.
- MaxLineSize, 8: maximum samples per line; sets the depth of each buffer bank.
- DoubleBuff, 1: 1 = two banks (ping-pong); 0 = single bank, where input stalls until the bank is drained.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DataWidth  input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept the input sample.
- in_sof  in  1  first sample of a frame (on line 0, index 0).
- in_eol  in  1  last sample of the current line.
- out_data  out  DataWidth  reordered sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_sof  out  1  first output sample of a line whose first input carried sof.
- out_eol  out  1  last output sample of the line.
- (In the codebase the in_* and out_* groups are each bundled as an Axis interface instance named `in` and `out`, sharing clk and rst.)

Behaviour:
- Handshakes:
  - A transfer occurs on a rising edge where valid and ready are both high.
  - in_ready must not depend combinationally on in_valid.
  - While out_valid=1 and out_ready=0, out_data, out_sof and out_eol hold stable.
- Write side:
  - Each accepted input is written to the current write bank at index waddr, starting at 0, and waddr increments.
  - The line ends on an accepted sample with in_eol=1, or when waddr reaches MaxLineSize-1 (a forced end of line). At that point:
    - N = waddr+1 is stored as the bank's length;
    - the sof flag of the line's first sample is stored with the bank;
    - the bank is marked full;
    - waddr returns to 0 and the write side moves to the other bank (DoubleBuff=1).
  - in_ready = 1 while the current write bank is not full.
- Read side:
  - When a full bank exists and the output register is free or being drained, read proceeds in this order:
    - even indices 0, 2, 4, …, up to the largest even index < N (count ceil(N/2));
    - then odd indices 1, 3, …, up to the largest odd index < N (count floor(N/2)).
  - out_sof = stored sof flag, on the first output of the line only.
  - out_eol = 1 on the N-th (last) output of the line.
  - After the last output is accepted, the bank is marked empty and reading moves to the other bank.
- Latency and throughput:
  - The first output of a line becomes valid no earlier than 1 cycle and no later than 2 cycles after the eol input transfer, provided that bank is next to be read.
  - With both handshakes continuously high and DoubleBuff=1, sustained throughput is one sample per cycle.
  - With DoubleBuff=0, input stalls (in_ready=0) from eol acceptance until the last output of that line is accepted.
- Boundaries:
  - N=1: a single output with out_eol=1.
  - Simultaneous write-complete and read-complete in the same cycle on different banks are both honoured.
  - Both banks full: in_ready=0.
  - An in_sof arriving mid-line is stored with no other effect; it is not propagated mid-line.
- Reset (asynchronous, any time):
  - out_valid=0, out_sof=0, out_eol=0, out_data=0;
  - in_ready=0 while rst=1, then 1 from the first clk after deassertion;
  - all banks empty, waddr=0, read pointers 0, write/read bank select = bank 0;
  - any partial line in progress is discarded.
  - Memory contents need not be reset.

Test Plan:
- Line 0x00..0x07 (sof on 0x00, eol on 0x07), out_ready=1 -> out 00,02,04,06,01,03,05,07; sof on 00, eol on 07.
- Eight consecutive lines 0x00.., 0x10.., … 0x70.. with random in_valid and random out_ready -> each line reordered as above, nothing lost or duplicated; sof only on line 0's first output.
- DoubleBuff=1 with continuous valid/ready -> second line is accepted while the first is read; steady state gives 1 sample/cycle.
- DoubleBuff=0 -> in_ready=0 from eol until 07 is accepted at the output.
- Odd line length 5 (A0..A4, eol on A4) -> A0,A2,A4,A1,A3, eol on A3; line length 1 -> single output with eol.
- Assert rst mid-line after 3 writes -> outputs clear immediately; the next full line is output correctly with no residue.

Source files
------------

// File: rtl/in_line_reorder.sv
// rtl/in_line_reorder.sv - line buffer that re-emits interleaved low/high-pass samples as all evens then all odds
module in_line_reorder #(
  parameter int DataWidth   = 8,
  parameter int MaxLineSize = 8,
  parameter int DoubleBuff  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic                 in_eol,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eol
);
  localparam int AW = $clog2(MaxLineSize);
  localparam int LW = $clog2(MaxLineSize + 1);

  logic [DataWidth-1:0] mem [2][MaxLineSize];
  logic [1:0]           full;
  logic [LW-1:0]        len [2];
  logic [1:0]           bank_sof;
  logic                 wsel;
  logic                 rsel;
  logic [AW-1:0]        waddr;
  logic                 line_sof;
  logic [LW-1:0]        rcnt;
  logic                 run;

  logic          in_fire;
  logic          line_done;
  logic          last_acc;
  logic          free_w;
  logic          cur_bank;
  logic          cur_full;
  logic          load;
  logic [LW-1:0] cur_cnt;
  logic [LW-1:0] cur_len;
  logic [LW-1:0] half;
  logic [AW-2:0] odd_k;
  logic [AW-1:0] raddr;

  // A bank whose last sample is being accepted counts as free this cycle, so
  // ping-pong operation never inserts a bubble on either side.
  assign last_acc  = out_valid && out_ready && out_eol;
  assign free_w    = (DoubleBuff != 0) && last_acc && (rsel == wsel);
  assign in_ready  = run && (!full[wsel] || free_w);
  assign in_fire   = in_valid && in_ready;
  assign line_done = in_fire && (in_eol || (waddr == AW'(MaxLineSize - 1)));

  assign cur_bank = ((DoubleBuff != 0) && last_acc) ? !rsel : rsel;
  assign cur_full = full[cur_bank] && !(last_acc && (cur_bank == rsel));
  assign cur_cnt  = last_acc ? '0 : rcnt;
  assign cur_len  = len[cur_bank];
  assign half     = (cur_len + LW'(1)) >> 1;
  assign load     = cur_full && (cur_cnt < cur_len) && (!out_valid || out_ready);

  // Output slot k < ceil(N/2) reads index 2k, the rest read 2(k-ceil(N/2))+1.
  assign odd_k = cur_cnt[AW-2:0] - half[AW-2:0];
  assign raddr = (cur_cnt < half) ? {cur_cnt[AW-2:0], 1'b0} : {odd_k, 1'b1};

  always_ff @(posedge clk) begin
    if (in_fire) mem[wsel][waddr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      full     <= '0;
      len[0]   <= '0;
      len[1]   <= '0;
      bank_sof <= '0;
      wsel     <= 1'b0;
      rsel     <= 1'b0;
      waddr    <= '0;
      line_sof <= 1'b0;
      rcnt     <= '0;
    end else begin
      run <= 1'b1;
      if (in_fire) begin
        if (waddr == '0) line_sof <= in_sof;
        if (line_done) begin
          waddr <= '0;
          if (DoubleBuff != 0) wsel <= !wsel;
        end else begin
          waddr <= waddr + AW'(1);
        end
      end
      // Clear before set: a bank freed and refilled on the same edge ends up full.
      if (last_acc) begin
        full[rsel] <= 1'b0;
        rsel       <= cur_bank;
        rcnt       <= '0;
      end
      if (line_done) begin
        full[wsel]     <= 1'b1;
        len[wsel]      <= LW'(waddr) + LW'(1);
        bank_sof[wsel] <= (waddr == '0) ? in_sof : line_sof;
      end
      if (load) rcnt <= cur_cnt + LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mem[cur_bank][raddr];
      out_sof   <= bank_sof[cur_bank] && (cur_cnt == '0);
      out_eol   <= (cur_cnt == cur_len - LW'(1));
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_in_line_reorder.sv
// tb/tb_in_line_reorder.sv - self-checking bench for in_line_reorder (ping-pong and single-bank)
module tb_in_line_reorder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_sof, out_eol;
  logic       out_ready = 1'b0;

  logic [7:0] sb_in_data = '0;
  logic       sb_in_valid = 1'b0, sb_in_sof = 1'b0, sb_in_eol = 1'b0, sb_in_ready;
  logic [7:0] sb_out_data;
  logic       sb_out_valid, sb_out_sof, sb_out_eol;
  logic       sb_out_ready = 1'b0;

  in_line_reorder #(.DataWidth(8), .MaxLineSize(8), .DoubleBuff(1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_eol(in_eol),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol)
  );

  in_line_reorder #(.DataWidth(8), .MaxLineSize(8), .DoubleBuff(0)) dut_sb (
    .clk(clk), .rst(rst),
    .in_data(sb_in_data), .in_valid(sb_in_valid), .in_ready(sb_in_ready), .in_sof(sb_in_sof), .in_eol(sb_in_eol),
    .out_data(sb_out_data), .out_valid(sb_out_valid), .out_ready(sb_out_ready), .out_sof(sb_out_sof), .out_eol(sb_out_eol)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int n_xfer = 0, first_xfer = 0, last_xfer = 0;
  logic [7:0] lbuf [8];
  logic [9:0] exp_q [$];
  logic [9:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: evens in order, then odds; sof on first output only, eol on last.
  task automatic push_expected(input int n, input bit sof, input bit to_sb);
    logic [9:0] e;
    int k;
    k = 0;
    for (int i = 0; i < n; i += 2) begin
      e = {lbuf[i], sof && (k == 0), k == n - 1};
      if (to_sb) sb_q.push_back(e); else exp_q.push_back(e);
      k++;
    end
    for (int i = 1; i < n; i += 2) begin
      e = {lbuf[i], sof && (k == 0), k == n - 1};
      if (to_sb) sb_q.push_back(e); else exp_q.push_back(e);
      k++;
    end
  endtask

  task automatic send_sample(input logic [7:0] d, input logic s, input logic e, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_sof = s; in_eol = e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    chk("in_accept_timeout", t < 200, 1);
  endtask

  task automatic send_line(input int n, input bit sof0, input int mid_sof, input bit use_eol, input bit gaps);
    for (int i = 0; i < n; i++)
      send_sample(lbuf[i], (i == 0 && sof0) || i == mid_sof, use_eol && i == n - 1, gaps);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && out_valid && out_ready) begin
      n_xfer++;
      if (n_xfer == 1) first_xfer = cyc;
      last_xfer = cyc;
      chk("out_unexpected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_sample", {out_data, out_sof, out_eol}, e);
      end
    end
  end

  initial begin
    int t, k, seen;
    logic [9:0] e;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_flags", {out_sof, out_eol}, 0);
    chk("rst_sb_in_ready", sb_in_ready, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_sb_in_ready", sb_in_ready, 1);

    // Basic line 00..07, out_ready high, first-output latency
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) lbuf[i] = 8'(i);
    push_expected(8, 1, 0);
    send_line(8, 1, -1, 1, 0);
    seen = 0;
    for (int i = 0; i < 2; i++) if (seen == 0) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("first_out_latency", seen, 1);
    drain();

    // Eight lines, random valid gaps and random out_ready
    rdy_mode = 2;
    for (int l = 0; l < 8; l++) begin
      for (int i = 0; i < 8; i++) lbuf[i] = 8'(l * 16 + i);
      push_expected(8, l == 0, 0);
      send_line(8, l == 0, -1, 1, 1);
    end
    drain();

    // Back-to-back lines with everything high: one output per cycle
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    n_xfer = 0;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 8; i++) lbuf[i] = 8'($urandom);
      push_expected(8, 0, 0);
      send_line(8, 0, -1, 1, 0);
    end
    drain();
    chk("tput_count", n_xfer, 32);
    chk("tput_span", last_xfer - first_xfer + 1, 32);

    // Forced end of line, odd length with a mid-line sof, length 1
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) lbuf[i] = 8'(8'h80 + i);
    push_expected(8, 0, 0);
    send_line(8, 0, -1, 0, 1);
    for (int i = 0; i < 5; i++) lbuf[i] = 8'(8'hA0 + i);
    push_expected(5, 0, 0);
    send_line(5, 0, 2, 1, 1);
    lbuf[0] = 8'h5A;
    push_expected(1, 1, 0);
    send_line(1, 1, -1, 1, 1);
    drain();

    // Single bank: input stalls from eol until the last output is accepted
    for (int i = 0; i < 8; i++) lbuf[i] = 8'(8'h30 + i);
    push_expected(8, 1, 1);
    for (int i = 0; i < 8; i++) begin
      sb_in_valid = 1'b1; sb_in_data = lbuf[i]; sb_in_sof = (i == 0); sb_in_eol = (i == 7);
      t = 0;
      @(negedge clk);
      while (!sb_in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk); #1;
      chk("sb_in_accept_timeout", t < 50, 1);
    end
    sb_in_valid = 1'b0; sb_in_sof = 1'b0; sb_in_eol = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("sb_stall_held", sb_in_ready, 0);
    end
    @(posedge clk); #1;
    sb_out_ready = 1'b1;
    k = 0; t = 0;
    while (k < 8 && t < 50) begin
      @(negedge clk);
      t++;
      chk("sb_stall_draining", sb_in_ready, 0);
      if (sb_out_valid && sb_out_ready) begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
        chk("sb_out_sample", {sb_out_data, sb_out_sof, sb_out_eol}, e);
        k++;
      end
    end
    @(posedge clk); #1;
    chk("sb_out_count", k, 8);
    chk("sb_ready_after_drain", sb_in_ready, 1);
    sb_out_ready = 1'b0;

    // Reset mid-line with a held output and a partial line in the buffer
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) lbuf[i] = 8'(8'h60 + i);
    push_expected(4, 1, 0);
    send_line(4, 1, -1, 1, 0);
    for (int i = 0; i < 3; i++) lbuf[i] = 8'(8'hE0 + i);
    send_line(3, 0, -1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, 8'h60);
    chk("hold_sof", out_sof, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_flags", {out_sof, out_eol}, 0);
    chk("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_back", in_ready, 1);
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) lbuf[i] = 8'(8'hC0 + i);
    push_expected(8, 1, 0);
    send_line(8, 1, -1, 1, 0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("final_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
